// File: rtl/fft_stage_sequencer_pkg.sv
// Shared definitions for the FFT stage sequencer: state encoding,
// stage-number width and the one-hot stage-enable helper.
package fft_pkg;

  localparam int STAGE_NUM_W = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_GAP    = 3'd3,
    S_UNLOAD = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } seq_state_t;

  // One-hot enable mask for a stage number (widest possible stage set).
  function automatic logic [2**STAGE_NUM_W-1:0] stage_mask(input logic [STAGE_NUM_W-1:0] k);
    stage_mask    = '0;
    stage_mask[k] = 1'b1;
  endfunction

endpackage

// File: rtl/fft_stage_watchdog.sv
// Per-stage timeout counter and sticky error flag for the FFT stage
// sequencer. Only compiled when STAGE_WATCHDOG_EN is defined.
`ifdef STAGE_WATCHDOG_EN
module fft_stage_watchdog #(
  parameter int STAGE_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic run,        // sequencer is in RUN this cycle
  input  logic done_q,     // qualified stage_done this cycle
  input  logic clear_err,  // start accepted this cycle
  output logic timeout,    // last allowed RUN cycle passed without done
  output logic err
);

  localparam int CW = $clog2(STAGE_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STAGE_TIMEOUT - 1);

  logic [CW-1:0] cnt_reg;
  logic          err_reg;

  // Cycle counter: zero outside RUN, so every RUN entry starts from zero.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign timeout = run && !done_q && (cnt_reg == CNT_LAST);

  // Sticky error flag: set on timeout, cleared by reset or an accepted start.
  always_ff @(posedge clk) begin
    if (rst || clear_err) begin
      err_reg <= 1'b0;
    end else if (timeout) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;

endmodule
`endif

// File: rtl/fft_stage_sequencer.sv
// Top-level FFT stage sequencer: load phase, one RUN per butterfly stage
// separated by a single idle GAP cycle, unload phase, then a done pulse.
// Optional per-stage watchdog enabled by defining STAGE_WATCHDOG_EN.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int NUMSTAGES     = 5,
  parameter int XFER_CYCLES   = 2 ** (NUMSTAGES - 2),
  parameter int STAGE_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stage_done,
  output logic                   ld_data,
  output logic [NUMSTAGES-1:0]   en,
  output logic [STAGE_NUM_W-1:0] stage_num,
  output logic                   out_valid,
  output logic [NUMSTAGES-3:0]   xfer_idx,
  output logic                   busy,
  output logic                   fft_done,
  output logic                   err
);

  localparam int XW = NUMSTAGES - 2;
  localparam logic [XW-1:0]          XFER_LAST  = XW'(XFER_CYCLES - 1);
  localparam logic [STAGE_NUM_W-1:0] STAGE_LAST = STAGE_NUM_W'(NUMSTAGES - 1);

  // Reject configurations the counters cannot represent.
  if (NUMSTAGES < 3 || NUMSTAGES > 2 ** STAGE_NUM_W || STAGE_TIMEOUT < 2) begin : g_param_check
    $error("fft_stage_sequencer: unsupported NUMSTAGES or STAGE_TIMEOUT");
  end

  seq_state_t             state_reg, state_next;
  logic [XW-1:0]          xfer_reg, xfer_next;
  logic [STAGE_NUM_W-1:0] stage_reg, stage_next;
  logic                   run_arm_reg;
  logic                   en_on;
  logic                   done_q;
  logic                   timeout;

  // stage_done only counts from the second RUN cycle; a level left over
  // from the previous stage is still visible in GAP and the first RUN cycle.
  assign done_q = stage_done && run_arm_reg;

`ifdef STAGE_WATCHDOG_EN
  fft_stage_watchdog #(
    .STAGE_TIMEOUT(STAGE_TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .run      (state_reg == S_RUN),
    .done_q   (done_q),
    .clear_err(start && ((state_reg == S_IDLE) || (state_reg == S_ERR))),
    .timeout  (timeout),
    .err      (err)
  );
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // State, beat counter, stage counter and RUN qualification flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      xfer_reg    <= '0;
      stage_reg   <= '0;
      run_arm_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      xfer_reg    <= xfer_next;
      stage_reg   <= stage_next;
      run_arm_reg <= (state_reg == S_RUN);
    end
  end

  // Next-state logic and Moore outputs decoded from the current state.
  always_comb begin
    state_next = state_reg;
    xfer_next  = xfer_reg;
    stage_next = stage_reg;
    ld_data    = 1'b0;
    en_on      = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    fft_done   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = S_LOAD;
          xfer_next  = '0;
          stage_next = '0;
        end
      end
      S_LOAD: begin
        ld_data   = 1'b1;
        xfer_next = xfer_reg + 1'b1;
        if (xfer_reg == XFER_LAST) begin
          state_next = S_RUN;
          xfer_next  = '0;
          stage_next = '0;
        end
      end
      S_RUN: begin
        en_on = 1'b1;
        if (done_q) begin
          state_next = (stage_reg == STAGE_LAST) ? S_UNLOAD : S_GAP;
        end else if (timeout) begin
          state_next = S_ERR;
        end
      end
      S_GAP: begin
        // stage_num steps only as GAP ends, so it is stable across RUN+GAP.
        state_next = S_RUN;
        stage_next = stage_reg + 1'b1;
      end
      S_UNLOAD: begin
        out_valid = 1'b1;
        xfer_next = xfer_reg + 1'b1;
        if (xfer_reg == XFER_LAST) begin
          state_next = S_DONE;
          xfer_next  = '0;
        end
      end
      S_DONE: begin
        fft_done   = 1'b1;
        state_next = S_IDLE;
      end
      S_ERR: begin
        if (start) begin
          state_next = S_LOAD;
          xfer_next  = '0;
          stage_next = '0;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign en        = en_on ? NUMSTAGES'(stage_mask(stage_reg)) : '0;
  assign stage_num = stage_reg;
  assign xfer_idx  = xfer_reg;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer: a stage-control model answers
// en with stage_done, and a per-cycle expected trace is queued at each start.
`timescale 1ns/1ps
module tb_fft_stage_sequencer;

  localparam int NS     = 5;
  localparam int XF     = 8;
  localparam int ST_LEN = 8;
  localparam int TO     = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stage_done = 1'b0;
  logic          ld_data;
  logic [NS-1:0] en;
  logic [2:0]    stage_num;
  logic          out_valid;
  logic [NS-3:0] xfer_idx;
  logic          busy;
  logic          fft_done;
  logic          err;

  fft_stage_sequencer #(
    .NUMSTAGES    (NS),
    .STAGE_TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stage_done(stage_done),
    .ld_data   (ld_data),
    .en        (en),
    .stage_num (stage_num),
    .out_valid (out_valid),
    .xfer_idx  (xfer_idx),
    .busy      (busy),
    .fft_done  (fft_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Packed view: err busy fft_done out_valid ld_data en[4:0] stage_num[2:0] xfer_idx[2:0]
  localparam logic [15:0] M_ALL  = 16'hFFFF;
  localparam logic [15:0] M_NOXI = 16'hFFF8;
  localparam logic [15:0] M_NOSN = 16'hFFC7;
  localparam logic [15:0] M_CTRL = 16'hFFC0;

  typedef struct {
    logic [15:0] val;
    logic [15:0] msk;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Stage-control model state.
  int          sticky_hold = 0;
  logic [NS-1:0] blk_mask  = '0;
  int          run_cnt     = 0;
  int          hold_cnt    = 0;
  logic [NS-1:0] last_en   = '0;

  // Stage model: stage_done rises in the ST_LEN-th cycle of en, optionally
  // lingers sticky_hold cycles after en drops; a blocked stage never finishes.
  always @(negedge clk) begin
    if (en != '0) begin
      run_cnt = (en == last_en) ? run_cnt + 1 : 1;
    end else begin
      if (last_en != '0 && stage_done) hold_cnt = sticky_hold;
      run_cnt = 0;
    end
    stage_done = ((en != '0) && (run_cnt >= ST_LEN) && (en != blk_mask)) || (hold_cnt > 0);
    if (hold_cnt > 0) hold_cnt = hold_cnt - 1;
    last_en = en;
  end

  function automatic logic [15:0] obs_vec();
    return {err, busy, fft_done, out_valid, ld_data, en, stage_num, xfer_idx};
  endfunction

  function automatic logic [15:0] pk(input logic e, input logic b, input logic d,
                                     input logic ov, input logic ld, input logic [4:0] ev,
                                     input logic [2:0] sn, input logic [2:0] xi);
    return {e, b, d, ov, ld, ev, sn, xi};
  endfunction

  task automatic push(input logic [15:0] v, input logic [15:0] m);
    exp_t x;
    x.val = v;
    x.msk = m;
    sb_q.push_back(x);
  endtask

  task automatic push_load();
    for (int i = 0; i < XF; i++) push(pk(0, 1, 0, 0, 1, 5'd0, 3'd0, 3'(i)), M_NOSN);
  endtask

  task automatic push_stage(input int s, input int len, input bit gap);
    for (int i = 0; i < len; i++) push(pk(0, 1, 0, 0, 0, 5'(1 << s), 3'(s), 3'd0), M_NOXI);
    if (gap) push(pk(0, 1, 0, 0, 0, 5'd0, 3'(s), 3'd0), M_NOXI);
  endtask

  task automatic push_tail();
    for (int i = 0; i < XF; i++) push(pk(0, 1, 0, 1, 0, 5'd0, 3'd0, 3'(i)), M_NOSN);
    push(pk(0, 1, 1, 0, 0, 5'd0, 3'd0, 3'd0), M_CTRL);
    for (int i = 0; i < 2; i++) push(pk(0, 0, 0, 0, 0, 5'd0, 3'd0, 3'd0), M_NOSN);
  endtask

  task automatic push_transform();
    push_load();
    for (int s = 0; s < NS; s++) push_stage(s, ST_LEN, s < NS - 1);
    push_tail();
  endtask

  task automatic test_reset();
    exp_t e;
    logic [15:0] o;
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    push(16'h0000, M_ALL);
    e = sb_q.pop_front(); o = obs_vec(); n_cmp++;
    if ((o & e.msk) !== (e.val & e.msk)) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", o, e.val);
    end
    rst = 1'b0;
    start = 1'b0;
    push(16'h0000, M_ALL);
    @(negedge clk);
    e = sb_q.pop_front(); o = obs_vec(); n_cmp++;
    if ((o & e.msk) !== (e.val & e.msk)) begin
      n_fail++; $display("FAIL idle_after_reset: got %h expected %h", o, e.val);
    end
    $display("reset: state checked");
  endtask

  task automatic test_basic();
    exp_t e;
    logic [15:0] o;
    int cyc = 0;
    int done_cyc = -1;
    int exp_lat = 1 + XF + NS * ST_LEN + (NS - 1) + XF + 1;
    start = 1'b1;
    push_transform();
    while (sb_q.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      e = sb_q.pop_front(); o = obs_vec(); n_cmp++;
      if ((o & e.msk) !== (e.val & e.msk)) begin
        n_fail++; $display("FAIL basic cyc %0d: got %h expected %h mask %h", cyc, o, e.val, e.msk);
      end
      if (fft_done && done_cyc < 0) done_cyc = cyc;
    end
    n_cmp++;
    if (done_cyc + 1 !== exp_lat) begin
      n_fail++; $display("FAIL basic_latency: got %0d expected %0d", done_cyc + 1, exp_lat);
    end
    $display("basic: transform of %0d cycles checked", cyc);
  endtask

  task automatic test_sticky();
    exp_t e;
    logic [15:0] o;
    int cyc = 0;
    sticky_hold = 2;
    start = 1'b1;
    push_transform();
    while (sb_q.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      e = sb_q.pop_front(); o = obs_vec(); n_cmp++;
      if ((o & e.msk) !== (e.val & e.msk)) begin
        n_fail++; $display("FAIL sticky cyc %0d: got %h expected %h mask %h", cyc, o, e.val, e.msk);
      end
    end
    sticky_hold = 0;
    $display("sticky: transform of %0d cycles checked", cyc);
  endtask

  task automatic test_start_ignored();
    exp_t e;
    logic [15:0] o;
    int cyc = 0;
    int n_done = 0;
    start = 1'b1;
    push_transform();
    while (sb_q.size() > 0) begin
      @(negedge clk);
      cyc++;
      e = sb_q.pop_front(); o = obs_vec(); n_cmp++;
      if ((o & e.msk) !== (e.val & e.msk)) begin
        n_fail++; $display("FAIL start_busy cyc %0d: got %h expected %h mask %h", cyc, o, e.val, e.msk);
      end
      if (fft_done) n_done++;
      start = (cyc == 3) || (cyc == 38);
    end
    start = 1'b0;
    n_cmp++;
    if (n_done !== 1) begin
      n_fail++; $display("FAIL start_busy_done_count: got %0d expected 1", n_done);
    end
    $display("start_busy: %0d done pulses", n_done);
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    logic [15:0] o;
    int cyc = 0;
    bit found = 0;
    start = 1'b1;
    push_transform();
    while (sb_q.size() > 0 && !found) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      e = sb_q.pop_front(); o = obs_vec(); n_cmp++;
      if ((o & e.msk) !== (e.val & e.msk)) begin
        n_fail++; $display("FAIL midrst cyc %0d: got %h expected %h mask %h", cyc, o, e.val, e.msk);
      end
      if (en == 5'b00100) found = 1;
    end
    n_cmp++;
    if (found !== 1'b1) begin
      n_fail++; $display("FAIL midrst_reach_stage2: got %0d expected 1", found);
    end
    sb_q.delete();
    rst = 1'b1;
    push(16'h0000, M_ALL);
    @(negedge clk);
    e = sb_q.pop_front(); o = obs_vec(); n_cmp++;
    if ((o & e.msk) !== (e.val & e.msk)) begin
      n_fail++; $display("FAIL midrst_abort: got %h expected %h", o, e.val);
    end
    rst = 1'b0;
    start = 1'b1;
    push_transform();
    cyc = 0;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      e = sb_q.pop_front(); o = obs_vec(); n_cmp++;
      if ((o & e.msk) !== (e.val & e.msk)) begin
        n_fail++; $display("FAIL midrst_rerun cyc %0d: got %h expected %h mask %h", cyc, o, e.val, e.msk);
      end
    end
    $display("reset_mid_run: abort and rerun checked");
  endtask

  task automatic test_watchdog();
    exp_t e;
    logic [15:0] o;
    int cyc = 0;
    blk_mask = 5'b00010;
    start = 1'b1;
    push_load();
    push_stage(0, ST_LEN, 1'b1);
    push_stage(1, TO, 1'b0);
`ifdef STAGE_WATCHDOG_EN
    for (int i = 0; i < 4; i++) push(pk(1, 1, 0, 0, 0, 5'd0, 3'd0, 3'd0), M_CTRL);
`else
    push_stage(1, 200 - TO, 1'b0);
`endif
    while (sb_q.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      e = sb_q.pop_front(); o = obs_vec(); n_cmp++;
      if ((o & e.msk) !== (e.val & e.msk)) begin
        n_fail++; $display("FAIL watchdog cyc %0d: got %h expected %h mask %h", cyc, o, e.val, e.msk);
      end
    end
    blk_mask = '0;
`ifndef STAGE_WATCHDOG_EN
    rst = 1'b1;
    push(16'h0000, M_ALL);
    @(negedge clk);
    e = sb_q.pop_front(); o = obs_vec(); n_cmp++;
    if ((o & e.msk) !== (e.val & e.msk)) begin
      n_fail++; $display("FAIL watchdog_off_reset: got %h expected %h", o, e.val);
    end
    rst = 1'b0;
`endif
    start = 1'b1;
    push_transform();
    cyc = 0;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      e = sb_q.pop_front(); o = obs_vec(); n_cmp++;
      if ((o & e.msk) !== (e.val & e.msk)) begin
        n_fail++; $display("FAIL watchdog_recover cyc %0d: got %h expected %h mask %h", cyc, o, e.val, e.msk);
      end
    end
    $display("watchdog: stall and recovery checked");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sticky();
    test_start_ignored();
    test_reset_mid_run();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time bound so a stuck run still terminates.
  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
